// File: rtl/motion_pkg.sv
// motion_pkg
// Shared definitions for the motion command sequencer:
//   - motor speed words (ZERO, PULL, PUSH, DN)
//   - ASCII command byte codes
//   - sequencer state enum {IDLE, LOAD, RAMP, HOLD}
//   - cmd_decode : byte -> valid flag plus four 9-bit motor targets
//   - cmd_known  : byte -> 1 when the byte is a recognised command
// Slew limiting is enabled in the sequencer by defining MOTION_SLEW_EN.
package motion_pkg;

  localparam logic [8:0] ZERO = 9'h000;
  localparam logic [8:0] PULL = 9'h002;
  localparam logic [8:0] PUSH = 9'h080;
  localparam logic [8:0] DN   = 9'h0FF;

  localparam logic [7:0] CMD_FWD   = 8'h66;  // 'f'
  localparam logic [7:0] CMD_BACK  = 8'h62;  // 'b'
  localparam logic [7:0] CMD_RIGHT = 8'h72;  // 'r'
  localparam logic [7:0] CMD_LEFT  = 8'h6C;  // 'l'
  localparam logic [7:0] CMD_UP    = 8'h75;  // 'u'
  localparam logic [7:0] CMD_DOWN  = 8'h64;  // 'd'
  localparam logic [7:0] CMD_STOP  = 8'h73;  // 's'

  typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_t;

  // Element [m] of target is the speed target for motor m.
  typedef struct packed {
    logic             valid;
    logic [3:0][8:0]  target;
  } decode_t;

  // Packs per-motor targets so that motor 0 lands in element [0].
  function automatic logic [3:0][8:0] pack4(input logic [8:0] m0, input logic [8:0] m1,
                                            input logic [8:0] m2, input logic [8:0] m3);
    return {m3, m2, m1, m0};
  endfunction

  function automatic decode_t cmd_decode(input logic [7:0] b);
    decode_t d;
    d.valid  = 1'b1;
    d.target = pack4(ZERO, ZERO, ZERO, ZERO);
    case (b)
      CMD_FWD:   d.target = pack4(PULL, PULL, PUSH, PUSH);
      CMD_BACK:  d.target = pack4(PUSH, PUSH, PULL, PULL);
      CMD_RIGHT: d.target = pack4(PUSH, PULL, PULL, PUSH);
      CMD_LEFT:  d.target = pack4(PULL, PUSH, PUSH, PULL);
      CMD_UP:    d.target = pack4(PULL, PULL, PULL, PULL);
      CMD_DOWN:  d.target = pack4(DN, DN, DN, DN);
      CMD_STOP:  d.target = pack4(ZERO, ZERO, ZERO, ZERO);
      default:   d.valid  = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic cmd_known(input logic [7:0] b);
    return b inside {CMD_FWD, CMD_BACK, CMD_RIGHT, CMD_LEFT, CMD_UP, CMD_DOWN, CMD_STOP};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
// Small synchronous FIFO holding raw command bytes.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write din when not full
//   pop/dout : dout shows the head; pop removes it when not empty
//   flush    : empties the FIFO (takes priority over push and pop)
//   full, empty : derived from the registered occupancy count
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/motion_cmd_sequencer.sv
// motion_cmd_sequencer
// Queues motion command bytes and executes them one at a time, driving
// the four PWM timer speed words. Each command's targets are reached
// (slew-limited when MOTION_SLEW_EN is defined, otherwise in one cycle)
// and then held for HOLD_TICKS ticks. 's' flushes the queue and ramps
// every motor to zero from any state.
//   clk, rst              : clock, asynchronous active-high reset
//   tick                  : one-cycle timebase strobe
//   cmd_valid, cmd_byte   : offered ASCII command
//   cmd_ready             : queue has room (registered occupancy only)
//   speed0..speed3        : motor speed words
//   busy                  : sequencer not IDLE
//   err_cmd               : one-cycle pulse after an unknown byte is dropped
// Configuration macro: MOTION_SLEW_EN
module motion_cmd_sequencer
  import motion_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         HOLD_TICKS = 250,
  parameter logic [8:0] RAMP_STEP  = 9'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic [8:0] speed0,
  output logic [8:0] speed1,
  output logic [8:0] speed2,
  output logic [8:0] speed3,
  output logic       busy,
  output logic       err_cmd
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  state_t          state_q;
  state_t          state_d;
  logic [HW-1:0]   hold_cnt;
  logic [3:0][8:0] target_q;
  logic [3:0][8:0] speed_q;
  logic [8:0]      speed_nxt [4];

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  decode_t    head_dec;

  logic is_stop;
  logic stop_evt;
  logic accept;
  logic ramp_en;
  logic ramp_done;

  assign cmd_ready = !fifo_full;
  assign is_stop   = (cmd_byte == CMD_STOP);
  // 's' is taken even when the queue is full.
  assign stop_evt  = cmd_valid && is_stop;
  assign accept    = cmd_valid && (cmd_ready || is_stop);
  assign fifo_push = accept && !is_stop && cmd_known(cmd_byte);
  assign head_dec  = cmd_decode(fifo_head);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (stop_evt),
    .din   (cmd_byte),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Per-motor next speed while ramping.
  for (genvar m = 0; m < 4; m++) begin : g_motor
`ifdef MOTION_SLEW_EN
    logic [8:0] step_val;
    // Move by at most RAMP_STEP; the guarded add/subtract can never wrap.
    always_comb begin
      step_val = target_q[m];
      if (target_q[m] > speed_q[m]) begin
        if ((target_q[m] - speed_q[m]) > RAMP_STEP) step_val = speed_q[m] + RAMP_STEP;
      end else if ((speed_q[m] - target_q[m]) > RAMP_STEP) begin
        step_val = speed_q[m] - RAMP_STEP;
      end
    end
    assign speed_nxt[m] = step_val;
`else
    assign speed_nxt[m] = target_q[m];
`endif
  end

`ifdef MOTION_SLEW_EN
  assign ramp_en   = (state_q == RAMP) && tick && !stop_evt;
  assign ramp_done = (speed_q == target_q);
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^RAMP_STEP;
  assign ramp_en   = (state_q == RAMP) && !stop_evt;
  assign ramp_done = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and FIFO pop; a stop byte overrides whatever the state wanted.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        fifo_pop = 1'b1;
        state_d  = RAMP;
      end
      RAMP: if (ramp_done) state_d = HOLD;
      HOLD: if (tick && hold_cnt == HW'(1)) state_d = fifo_empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
    if (stop_evt) begin
      state_d  = RAMP;
      fifo_pop = 1'b0;
    end
  end

  // Hold counter is loaded as the ramp completes and counts ticks down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                hold_cnt <= '0;
    else if (stop_evt)                      hold_cnt <= '0;
    else if (state_q == RAMP && ramp_done)  hold_cnt <= HW'(HOLD_TICKS);
    else if (state_q == HOLD && tick)       hold_cnt <= hold_cnt - HW'(1);
  end

  // Targets change only on stop (to zero) or when a command is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      target_q <= '0;
    else if (stop_evt)                            target_q <= '0;
    else if (state_q == LOAD && head_dec.valid)   target_q <= head_dec.target;
  end

  // Speeds move only while ramping, so cmd_byte never reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          speed_q <= '0;
    else if (ramp_en) speed_q <= {speed_nxt[3], speed_nxt[2], speed_nxt[1], speed_nxt[0]};
  end

  // Unknown bytes are swallowed and flagged one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cmd <= 1'b0;
    else     err_cmd <= accept && !cmd_known(cmd_byte);
  end

  assign busy   = (state_q != IDLE);
  assign speed0 = speed_q[0];
  assign speed1 = speed_q[1];
  assign speed2 = speed_q[2];
  assign speed3 = speed_q[3];

endmodule
